// File: rtl/rr_port_arbitrator_if.sv
// -----------------------------------------------------------------------------
// rr_port_arbitrator_if
// Handshake bundle between the per-port input FIFOs / write-path mux and the
// round-robin port arbiter.
//
//   i_req        [PORTNUM]  per-port packet request (level, held until granted)
//   i_ready      [PORTNUM]  per-port ready; request counts only when ready
//   i_eop                   end of the granted packet
//   o_port_ready            arbiter idle
//   o_resp       [PORTNUM]  one-hot grant pulse (one cycle)
//   o_nresp      [PORTNUM]  bitwise inverse of o_resp
//   o_en                    write path enable, high while a packet is granted
//   o_sel        [SEL_W]    index of the granted port, held after release
//   o_timeout               forced-release pulse from the packet-length watchdog
//
// Modports: master = port/FIFO side (drives requests), slave = arbiter.
// -----------------------------------------------------------------------------
interface rr_port_arbitrator_if #(
  parameter int PORTNUM = 16
);
  localparam int SEL_W = $clog2(PORTNUM);

  logic [PORTNUM-1:0] i_req;
  logic [PORTNUM-1:0] i_ready;
  logic               i_eop;
  logic               o_port_ready;
  logic [PORTNUM-1:0] o_resp;
  logic [PORTNUM-1:0] o_nresp;
  logic               o_en;
  logic [SEL_W-1:0]   o_sel;
  logic               o_timeout;

  modport master (
    output i_req, i_ready, i_eop,
    input  o_port_ready, o_resp, o_nresp, o_en, o_sel, o_timeout
  );

  modport slave (
    input  i_req, i_ready, i_eop,
    output o_port_ready, o_resp, o_nresp, o_en, o_sel, o_timeout
  );
endinterface

// File: rtl/rr_port_arbitrator.sv
// -----------------------------------------------------------------------------
// rr_port_arbitrator
// Packet-level round-robin arbiter: grants one of PORTNUM ports the shared
// cache write path for exactly one packet at a time. Priority rotates so the
// port after the last granted one is searched first.
//
// Parameters:
//   PORTNUM  number of ports (2..64)
//   MAXLEN   watchdog limit in BUSY cycles (>= 2), watchdog build only
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   bus      rr_port_arbitrator_if.slave (request/ready/eop in,
//            port_ready/resp/nresp/en/sel/timeout out)
//
// Build option:
//   PORT_ARB_WATCHDOG_EN  when defined, a packet that stays BUSY for MAXLEN
//                         cycles without i_eop is force-released and
//                         o_timeout pulses; otherwise o_timeout is tied low.
// -----------------------------------------------------------------------------
module rr_port_arbitrator #(
  parameter int PORTNUM = 16,
  parameter int MAXLEN  = 1024
) (
  input logic                 i_clk,
  input logic                 i_rst,
  rr_port_arbitrator_if.slave bus
);

  localparam int SEL_W = $clog2(PORTNUM);

  if (PORTNUM < 2 || PORTNUM > 64 || MAXLEN < 2) begin : g_bad_param
    $error("rr_port_arbitrator: PORTNUM must be 2..64 and MAXLEN >= 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [PORTNUM-1:0] eligible;
  logic [PORTNUM-1:0] resp_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;       // last granted index
  logic [SEL_W-1:0]   winner;
  logic               win_valid;
  logic               wd_expire;   // watchdog forces release at this edge

  assign eligible = bus.i_req & bus.i_ready;

  // Rotating search starting at ptr+1. Offsets are walked from farthest to
  // nearest so the nearest eligible port is the last (winning) assignment.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would make synthesis infer a latch.
    win_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int i = PORTNUM; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= PORTNUM) idx = idx - PORTNUM;
      if (eligible[SEL_W'(idx)]) begin
        win_valid = 1'b1;
        winner    = SEL_W'(idx);
      end
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (win_valid)                state_d = BUSY;
      BUSY: if (bus.i_eop || wd_expire)   state_d = IDLE;
    endcase
  end

  // Grant datapath: decision is captured only on the IDLE->BUSY edge, so
  // request/ready changes during BUSY cannot disturb the granted port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_q <= '0;
      sel_q  <= '0;
      ptr_q  <= SEL_W'(PORTNUM - 1);   // port 0 searched first after reset
    end else begin
      resp_q <= '0;                    // grant is a single-cycle pulse
      if (state_q == IDLE && win_valid) begin
        resp_q <= PORTNUM'(1) << winner;
        sel_q  <= winner;
        ptr_q  <= winner;
      end
    end
  end

`ifdef PORT_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAXLEN + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_q;

  // Counter value k-1 during BUSY cycle k, so the limit hit in cycle MAXLEN
  // gives BUSY exactly MAXLEN cycles. A coincident eop is a normal release.
  assign wd_expire = (state_q == BUSY) && !bus.i_eop &&
                     (wd_cnt_q == CNT_W'(MAXLEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (state_q == IDLE)  wd_cnt_q <= '0;
      else if (!bus.i_eop)  wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // ---- FSM: outputs ----
  always_comb begin
    bus.o_port_ready = (state_q == IDLE);
    bus.o_en         = (state_q == BUSY);
    bus.o_resp       = resp_q;
    bus.o_nresp      = ~resp_q;
    bus.o_sel        = sel_q;
`ifdef PORT_ARB_WATCHDOG_EN
    bus.o_timeout    = timeout_q;
`else
    bus.o_timeout    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_port_arbitrator.sv
// -----------------------------------------------------------------------------
// tb_rr_port_arbitrator
// Directed bench for rr_port_arbitrator (PORTNUM=16, MAXLEN=8): a vector table
// for the basic grant / ready / eop behaviour, then hand-written sequences for
// long packets, mid-packet reset, full round-robin rotation and the watchdog.
// -----------------------------------------------------------------------------
module tb_rr_port_arbitrator;

  localparam int PORTNUM = 16;
  localparam int MAXLEN  = 8;
`ifdef PORT_ARB_WATCHDOG_EN
  localparam int HOLD_EXTRA = 6;    // keep the long packet inside the limit
`else
  localparam int HOLD_EXTRA = 18;   // eop low for 20 BUSY cycles in total
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  rr_port_arbitrator_if #(.PORTNUM(PORTNUM)) bus ();

  rr_port_arbitrator #(.PORTNUM(PORTNUM), .MAXLEN(MAXLEN)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] ready;
    logic        eop;
    logic [15:0] resp;
    logic [3:0]  sel;
    logic        en;
    logic        pr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] resp,
                               input logic [3:0] sel, input logic en,
                               input logic pr, input logic to);
    logic [15:0] nresp;
    nresp = ~resp;
    check({tag, ".resp"},       32'(bus.o_resp),       32'(resp));
    check({tag, ".nresp"},      32'(bus.o_nresp),      32'(nresp));
    check({tag, ".sel"},        32'(bus.o_sel),        32'(sel));
    check({tag, ".en"},         32'(bus.o_en),         32'(en));
    check({tag, ".port_ready"}, 32'(bus.o_port_ready), 32'(pr));
    check({tag, ".timeout"},    32'(bus.o_timeout),    32'(to));
  endtask

  initial begin
    //               req       ready     eop   resp      sel  en  pr
    vecs[0] = '{16'h0005, 16'hFFFF, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[1] = '{16'h0004, 16'hFFFF, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b1};
    vecs[2] = '{16'h0004, 16'hFFFF, 1'b0, 16'h0004, 4'd2, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 4'd2, 1'b0, 1'b1};
    vecs[4] = '{16'h0003, 16'h0002, 1'b0, 16'h0002, 4'd1, 1'b1, 1'b0};
    vecs[5] = '{16'h0001, 16'h0002, 1'b1, 16'h0000, 4'd1, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'd1, 1'b0, 1'b1};
    vecs[8] = '{16'h0008, 16'hFFFF, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0};
    vecs[9] = '{16'h0080, 16'hFFFF, 1'b0, 16'h0000, 4'd3, 1'b1, 1'b0};

    bus.i_req   = '0;
    bus.i_ready = '1;
    bus.i_eop   = 1'b0;

    // Reset values
    i_rst = 1'b1;
    tick();
    tick();
    check_outputs("reset", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    i_rst = 1'b0;
    tick();
    check_outputs("post_reset_idle", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);

    // Vector table: grant order, ready qualification, eop in IDLE ignored
    for (int i = 0; i < 10; i++) begin
      bus.i_req   = vecs[i].req;
      bus.i_ready = vecs[i].ready;
      bus.i_eop   = vecs[i].eop;
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].resp, vecs[i].sel,
                    vecs[i].en, vecs[i].pr, 1'b0);
    end

    // Long packet on port 3 while request pattern changes: grant is held
    for (int i = 0; i < HOLD_EXTRA; i++) begin
      tick();
      check_outputs($sformatf("hold%0d", i), 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0);
    end
    bus.i_eop = 1'b1;
    tick();
    check_outputs("hold_release", 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0);
    bus.i_eop = 1'b0;
    tick();
    check_outputs("grant7", 16'h0080, 4'd7, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a packet, no eop
    bus.i_req = 16'hFFFF;
    i_rst     = 1'b1;
    tick();
    check_outputs("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    i_rst = 1'b0;
    tick();
    check_outputs("after_reset_grant0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);

    // Full rotation: all ports requesting, eop on every first BUSY cycle
    bus.i_eop = 1'b1;
    for (int k = 1; k <= PORTNUM; k++) begin
      logic [3:0]  exp_sel;
      logic [3:0]  prev_sel;
      logic [15:0] exp_resp;
      exp_sel  = 4'(k % PORTNUM);
      prev_sel = 4'(k - 1);
      exp_resp = 16'h0001 << exp_sel;
      tick();
      check_outputs($sformatf("rr_idle%0d", k), 16'h0000, prev_sel, 1'b0, 1'b1, 1'b0);
      tick();
      check_outputs($sformatf("rr_grant%0d", k), exp_resp, exp_sel, 1'b1, 1'b0, 1'b0);
    end
    bus.i_req = '0;
    tick();
    check_outputs("rr_end_idle", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);

    // Single eligible port wins even though it was the last granted
    bus.i_eop = 1'b0;
    bus.i_req = 16'h0001;
    tick();
    check_outputs("single_grant0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    bus.i_req = '0;

`ifdef PORT_ARB_WATCHDOG_EN
    // No eop: BUSY for exactly MAXLEN cycles, then forced release
    for (int c = 2; c <= MAXLEN; c++) begin
      tick();
      check_outputs($sformatf("wd_busy%0d", c), 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_outputs("wd_timeout", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
    bus.i_req = 16'hFFFF;
    tick();
    check_outputs("wd_ptr_advanced", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    bus.i_req = '0;
    // Eop arriving exactly in BUSY cycle MAXLEN is a normal release
    for (int c = 2; c <= MAXLEN; c++) begin
      tick();
      check_outputs($sformatf("wd_eop_busy%0d", c), 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
    end
    bus.i_eop = 1'b1;
    tick();
    check_outputs("wd_eop_at_limit", 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0);
    bus.i_eop = 1'b0;
    tick();
    check_outputs("wd_no_late_pulse", 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0);
`else
    // No watchdog: BUSY persists well beyond MAXLEN without eop
    for (int c = 2; c <= MAXLEN + 4; c++) begin
      tick();
      check_outputs($sformatf("nowd_busy%0d", c), 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    bus.i_eop = 1'b1;
    tick();
    check_outputs("nowd_release", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    bus.i_eop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_port_arbitrator.md
# rr_port_arbitrator

Packet-level round-robin arbiter that grants one of PORTNUM input ports access to the shared cache write path for exactly one packet at a time. It is the parametrised successor of the fixed-priority port arbiter: fair rotating priority, per-port ready qualification and an optional packet-length watchdog. It sits between the per-port input FIFOs and the write-path mux, which it drives through `o_en` and `o_sel`.

## Interface
- `PORTNUM`, 16, number of ports; legal range 2..64.
- `MAXLEN`, 1024, watchdog limit in BUSY cycles; legal range ≥ 2; used only with the watchdog compiled in.
- `i_clk`  input  1  clock; all logic on the rising edge.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_req`  input  PORTNUM  per-port packet request; level, held by the port until granted.
- `i_ready`  input  PORTNUM  per-port ready; a port is eligible only if `i_req[p] & i_ready[p]`.
- `i_eop`  input  1  end of the granted packet; sampled only in BUSY.
- `o_port_ready`  output  1  arbiter idle; high in IDLE.
- `o_resp`  output  PORTNUM  one-hot grant pulse, one cycle.
- `o_nresp`  output  PORTNUM  bitwise inverse of `o_resp` at all times.
- `o_en`  output  1  write path enabled; high throughout BUSY.
- `o_sel`  output  $clog2(PORTNUM)  index of the granted port; holds its value after release.
- `o_timeout`  output  1  one-cycle pulse on forced release by the watchdog.

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- `eligible = i_req & i_ready`.
- **IDLE → BUSY** when `eligible != 0`. Winner = the first set bit of `eligible`, searching upward from `ptr+1` modulo PORTNUM.
  - On entry: `o_sel <= winner`, `o_resp <= 1<<winner`, `o_en <= 1`, `ptr <= winner`.
- `ptr` is the last granted index. Reset value PORTNUM-1, so port 0 has top priority first.
- **BUSY → IDLE** when `i_eop = 1`: `o_en <= 0`. `o_sel` and `ptr` are held.
- In BUSY, changes on `i_req` and `i_ready` are ignored. A grant is never revoked except by `i_eop`, reset or the watchdog.
- `i_eop` in IDLE is ignored.
- With a single eligible port, that port wins regardless of `ptr`.
- `o_nresp` is driven as `~o_resp`; it is never independently registered to a different value.
- Reset values: state IDLE, `o_port_ready = 1`, `o_resp = 0`, `o_nresp` = all ones (PORTNUM wide), `o_en = 0`, `o_sel = 0`, `o_timeout = 0`, `ptr = PORTNUM-1`, watchdog counter 0.
- A reset asserted mid-packet returns the block to reset values on the next edge. No eop is required.

## Timing
- Arbitration decision is combinational in IDLE and registered at the edge. Grant latency is 1 cycle from the first eligible request in IDLE.
- `o_resp` is high for exactly the first BUSY cycle. `o_en` rises in the same cycle.
- `i_eop` may arrive in that first BUSY cycle; BUSY then lasts exactly 1 cycle.
- The edge that sees `i_eop` returns the FSM to IDLE. At least one IDLE cycle separates consecutive grants, so the maximum rate is one grant per 2 cycles.
- `o_port_ready = (state == IDLE)`, a combinational decode of the state register.

## Configuration
- `PORT_ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(MAXLEN+1)` clears on IDLE→BUSY and increments each BUSY cycle without `i_eop`.
  - When the counter reaches MAXLEN-1 and `i_eop = 0`, the next edge forces IDLE, clears `o_en` and pulses `o_timeout` for 1 cycle. BUSY therefore lasts exactly MAXLEN cycles.
  - `ptr` still advances past the timed-out port.
  - If `i_eop` coincides with the limit, this is a normal release and `o_timeout` stays 0.
- Not defined: no counter exists, `o_timeout` is tied to 0, and BUSY waits for `i_eop` indefinitely.

## Test plan
- Reset, then `i_req = 16'h0005`, `i_ready` all ones → cycle+1: `o_resp = 0x0001`, `o_sel = 0`, `o_en = 1`, `o_port_ready = 0`. Pulse eop → next grant `o_resp = 0x0004`, `o_sel = 2`.
- All 16 ports requesting continuously, eop on each first BUSY cycle → grants 0,1,…,15,0 in order, one every 2 cycles. `o_nresp == ~o_resp` every cycle.
- `i_req = 0x0003`, `i_ready = 0x0002` → grant port 1 only. With `i_ready = 0`, no grant and `o_port_ready` stays 1.
- During BUSY on port 3: drop `i_req[3]`, raise `i_req[7]`, hold eop low 20 cycles → `o_sel` stays 3 and `o_en` stays 1. Eop → release, then grant port 7.
- Assert `i_rst` in BUSY → next cycle all outputs at reset values. Next grant with `i_req` all ones → port 0.
- With `PORT_ARB_WATCHDOG_EN` and MAXLEN=8, no eop → `o_en` high 8 cycles, `o_timeout` pulse, return to IDLE. Eop at BUSY cycle 8 → no `o_timeout`.
